// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and data-memory freeze.
// Optional build macro STALL_COUNT_EN adds a saturating stall_count output.
module id_ex_stage #(
   parameter int SIZE = 32
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            mem_busy,
   input  logic            flush,
   input  logic [6:0]      opcode_id,
   input  logic [4:0]      rs1_id,
   input  logic [4:0]      rs2_id,
   input  logic [4:0]      rd_id,
   input  logic            reg_write_id,
   input  logic            mem_read_id,
   input  logic            mem_write_id,
   input  logic [3:0]      alu_ctrl_id,
   input  logic [SIZE-1:0] rs1_data_id,
   input  logic [SIZE-1:0] rs2_data_id,
   input  logic [SIZE-1:0] imm_id,
   input  logic [SIZE-1:0] pc_id,
   output logic [6:0]      opcode_ex,
   output logic [4:0]      rs1_ex,
   output logic [4:0]      rs2_ex,
   output logic [4:0]      rd_ex,
   output logic            reg_write_ex,
   output logic            mem_read_ex,
   output logic            mem_write_ex,
   output logic [3:0]      alu_ctrl_ex,
   output logic [SIZE-1:0] rs1_data_ex,
   output logic [SIZE-1:0] rs2_data_ex,
   output logic [SIZE-1:0] imm_ex,
   output logic [SIZE-1:0] pc_ex,
   output logic            stall,
`ifdef STALL_COUNT_EN
   output logic [31:0]     stall_count,
`endif
   output logic            bubble_ex
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_BUBBLE,
      ST_FREEZE
   } state_t;

   typedef struct packed {
      logic [6:0]      opcode;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic [3:0]      alu_ctrl;
      logic [SIZE-1:0] rs1_data;
      logic [SIZE-1:0] rs2_data;
      logic [SIZE-1:0] imm;
      logic [SIZE-1:0] pc;
   } ex_fields_t;

   ex_fields_t id_fields;
   ex_fields_t ex_q;
   state_t     state;
   logic       uses_rs1;
   logic       uses_rs2;
   logic       hazard;

   assign id_fields = '{opcode: opcode_id, rs1: rs1_id, rs2: rs2_id, rd: rd_id,
                        reg_write: reg_write_id, mem_read: mem_read_id,
                        mem_write: mem_write_id, alu_ctrl: alu_ctrl_id,
                        rs1_data: rs1_data_id, rs2_data: rs2_data_id,
                        imm: imm_id, pc: pc_id};

   // NOTE: both flags get a default before the case so no latch is inferred.
   always_comb begin
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      case (opcode_id)
         7'b0110011, 7'b1100011, 7'b0100011: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         7'b0010011, 7'b0000011, 7'b1100111: uses_rs1 = 1'b1;
         default: ;
      endcase
   end

   // A bubble in EX never carries mem_read, so one load can stall only once.
   assign hazard = (state != ST_BUBBLE) && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                   ((uses_rs1 && (ex_q.rd == rs1_id)) || (uses_rs2 && (ex_q.rd == rs2_id)));

   assign stall = !RESET && ((hazard && !flush) || mem_busy);

   // NOTE: every register here is written with <= so all fields change together at the edge.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ex_q      <= '0;
         bubble_ex <= 1'b0;
         state     <= ST_RUN;
      end else if (mem_busy) begin
         state <= ST_FREEZE;
      end else if (flush) begin
         ex_q      <= '0;
         bubble_ex <= 1'b0;
         state     <= ST_RUN;
      end else if (hazard) begin
         ex_q      <= '0;
         bubble_ex <= 1'b1;
         state     <= ST_BUBBLE;
      end else begin
         ex_q      <= id_fields;
         bubble_ex <= 1'b0;
         state     <= ST_RUN;
      end
   end

`ifdef STALL_COUNT_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         stall_count <= '0;
      else if (!mem_busy && !flush && hazard && (stall_count != 32'hFFFF_FFFF))
         stall_count <= stall_count + 32'd1;
   end
`endif

   assign opcode_ex    = ex_q.opcode;
   assign rs1_ex       = ex_q.rs1;
   assign rs2_ex       = ex_q.rs2;
   assign rd_ex        = ex_q.rd;
   assign reg_write_ex = ex_q.reg_write;
   assign mem_read_ex  = ex_q.mem_read;
   assign mem_write_ex = ex_q.mem_write;
   assign alu_ctrl_ex  = ex_q.alu_ctrl;
   assign rs1_data_ex  = ex_q.rs1_data;
   assign rs2_data_ex  = ex_q.rs2_data;
   assign imm_ex       = ex_q.imm;
   assign pc_ex        = ex_q.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic against a behavioural model.
module tb_id_ex_stage;
   localparam int SIZE = 32;

   logic            CLK = 1'b0;
   logic            RESET;
   logic            mem_busy, flush;
   logic [6:0]      opcode_id;
   logic [4:0]      rs1_id, rs2_id, rd_id;
   logic            reg_write_id, mem_read_id, mem_write_id;
   logic [3:0]      alu_ctrl_id;
   logic [SIZE-1:0] rs1_data_id, rs2_data_id, imm_id, pc_id;
   logic [6:0]      opcode_ex;
   logic [4:0]      rs1_ex, rs2_ex, rd_ex;
   logic            reg_write_ex, mem_read_ex, mem_write_ex;
   logic [3:0]      alu_ctrl_ex;
   logic [SIZE-1:0] rs1_data_ex, rs2_data_ex, imm_ex, pc_ex;
   logic            stall, bubble_ex;
`ifdef STALL_COUNT_EN
   logic [31:0]     stall_count;
   logic [31:0]     m_count;
`endif

   id_ex_stage #(.SIZE(SIZE)) dut (
      .CLK(CLK), .RESET(RESET), .mem_busy(mem_busy), .flush(flush),
      .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
      .reg_write_id(reg_write_id), .mem_read_id(mem_read_id), .mem_write_id(mem_write_id),
      .alu_ctrl_id(alu_ctrl_id), .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id),
      .imm_id(imm_id), .pc_id(pc_id),
      .opcode_ex(opcode_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
      .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
      .alu_ctrl_ex(alu_ctrl_ex), .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
      .imm_ex(imm_ex), .pc_ex(pc_ex), .stall(stall),
`ifdef STALL_COUNT_EN
      .stall_count(stall_count),
`endif
      .bubble_ex(bubble_ex)
   );

   always #5 CLK = ~CLK;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   // Expected EX contents, as the ID instruction that last entered EX (or an empty slot).
   typedef struct {
      logic [6:0]  opcode;
      logic [4:0]  rs1, rs2, rd;
      logic        rw, mr, mw;
      logic [3:0]  alu;
      logic [31:0] d1, d2, imm, pc;
   } ex_t;

   ex_t  m;
   logic m_bubble;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic ex_t empty_slot();
      ex_t e;
      e = '{opcode: 7'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, rw: 1'b0, mr: 1'b0, mw: 1'b0,
            alu: 4'd0, d1: 32'd0, d2: 32'd0, imm: 32'd0, pc: 32'd0};
      return e;
   endfunction

   function automatic logic model_hazard();
      logic reads1, reads2;
      reads1 = opcode_id inside {7'b0110011, 7'b1100011, 7'b0100011,
                                 7'b0010011, 7'b0000011, 7'b1100111};
      reads2 = opcode_id inside {7'b0110011, 7'b1100011, 7'b0100011};
      return m.mr && (m.rd != 0) && ((reads1 && m.rd == rs1_id) || (reads2 && m.rd == rs2_id));
   endfunction

   task automatic model_reset();
      m        = empty_slot();
      m_bubble = 1'b0;
`ifdef STALL_COUNT_EN
      m_count  = 0;
`endif
   endtask

   task automatic check_outputs(input string w);
      check({w, ".opcode"}, opcode_ex, m.opcode);
      check({w, ".rs1"}, rs1_ex, m.rs1);
      check({w, ".rs2"}, rs2_ex, m.rs2);
      check({w, ".rd"}, rd_ex, m.rd);
      check({w, ".reg_write"}, reg_write_ex, m.rw);
      check({w, ".mem_read"}, mem_read_ex, m.mr);
      check({w, ".mem_write"}, mem_write_ex, m.mw);
      check({w, ".alu"}, alu_ctrl_ex, m.alu);
      check({w, ".rs1_data"}, rs1_data_ex, m.d1);
      check({w, ".rs2_data"}, rs2_data_ex, m.d2);
      check({w, ".imm"}, imm_ex, m.imm);
      check({w, ".pc"}, pc_ex, m.pc);
      check({w, ".bubble"}, bubble_ex, m_bubble);
`ifdef STALL_COUNT_EN
      check({w, ".count"}, stall_count, m_count);
`endif
   endtask

   task automatic set_id(input logic [6:0] op, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic rw, input logic mr, input logic mw);
      opcode_id    = op;
      rs1_id       = s1;
      rs2_id       = s2;
      rd_id        = d;
      reg_write_id = rw;
      mem_read_id  = mr;
      mem_write_id = mw;
      alu_ctrl_id  = 4'($urandom_range(0, 15));
      rs1_data_id  = $urandom;
      rs2_data_id  = $urandom;
      imm_id       = $urandom;
      pc_id        = $urandom;
   endtask

   // Called right after inputs change at a falling edge; returns at the next falling edge.
   task automatic step(input string w);
      logic h;
      #1;
      h = model_hazard();
      check({w, ".stall"}, stall, (h && !flush) || mem_busy);
      @(posedge CLK);
      if (mem_busy) begin
         // frozen: everything held
      end else if (flush) begin
         m        = empty_slot();
         m_bubble = 1'b0;
      end else if (h) begin
         m        = empty_slot();
         m_bubble = 1'b1;
`ifdef STALL_COUNT_EN
         if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
`endif
      end else begin
         m = '{opcode: opcode_id, rs1: rs1_id, rs2: rs2_id, rd: rd_id, rw: reg_write_id,
               mr: mem_read_id, mw: mem_write_id, alu: alu_ctrl_id, d1: rs1_data_id,
               d2: rs2_data_id, imm: imm_id, pc: pc_id};
         m_bubble = 1'b0;
      end
      @(negedge CLK);
      check_outputs(w);
   endtask

   logic [6:0] ops [8];

   initial begin
      ops = '{OP_R, OP_LW, OP_SW, OP_LUI, 7'b1100011, 7'b0010011, 7'b1100111, 7'b1101111};
      RESET    = 1'b1;
      flush    = 1'b0;
      mem_busy = 1'b1;
      set_id(OP_LW, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0);
      model_reset();
      #2;
      check("reset.stall", stall, 1'b0);
      check_outputs("reset");
      @(negedge CLK);
      @(negedge CLK);
      RESET    = 1'b0;
      mem_busy = 1'b0;

      // ADD x3,x1,x2 passes straight through
      set_id(OP_R, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
      step("pass");
      check("pass.opcode_const", opcode_ex, OP_R);
      check("pass.rd_const", rd_ex, 5'd3);

      // LW x5 then ADD x6,x5,x7: one stall, one bubble, then ADD enters
      set_id(OP_LW, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
      step("lu_load");
      set_id(OP_R, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b0);
      step("lu_stall");
      check("lu.bubble_const", bubble_ex, 1'b1);
      step("lu_resume");
      check("lu.rd_const", rd_ex, 5'd6);

      // LUI-style opcode and x0 loads never stall
      set_id(OP_LW, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
      step("nu_load");
      set_id(OP_LUI, 5'd5, 5'd5, 5'd4, 1'b1, 1'b0, 1'b0);
      step("nu_lui");
      set_id(OP_LW, 5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      step("x0_load");
      set_id(OP_R, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
      step("x0_use");

      // SW x8,0(x9) after LW x8 stalls on rs2
      set_id(OP_LW, 5'd2, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
      step("st_load");
      set_id(OP_SW, 5'd9, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1);
      step("st_stall");
      check("st.bubble_const", bubble_ex, 1'b1);
      step("st_resume");

      // flush beats a simultaneous hazard
      set_id(OP_LW, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
      step("fh_load");
      set_id(OP_R, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0);
      flush = 1'b1;
      step("fh_flush");
      check("fh.bubble_const", bubble_ex, 1'b0);
      flush = 1'b0;

      // three-cycle freeze with a flush arriving mid-freeze
      set_id(OP_R, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
      step("fz_add");
      mem_busy = 1'b1;
      set_id(OP_R, 5'd4, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
      step("fz1");
      flush = 1'b1;
      step("fz2");
      step("fz3");
      mem_busy = 1'b0;
      step("fz_flush");
      flush = 1'b0;

      // reset arriving asynchronously in the middle of a freeze
      set_id(OP_LW, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
      step("rf_load");
      mem_busy = 1'b1;
      step("rf_busy");
      #2;
      RESET = 1'b1;
      #1;
      model_reset();
      check("rf.stall", stall, 1'b0);
      check_outputs("rf_reset");
      @(negedge CLK);
      RESET    = 1'b0;
      mem_busy = 1'b0;

      // random traffic with a small register range so collisions are common
      for (int i = 0; i < 3000; i++) begin
         set_id(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 9) < 5), 1'($urandom));
         flush    = ($urandom_range(0, 9) == 0);
         mem_busy = ($urandom_range(0, 19) < 3);
         step("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule
